// File: rtl/br_resolve_pkg.sv
// Shared types for the branch-resolution unit. The enums carry the core's rv32i_types encodings.
package br_resolve_pkg;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic {
    rs2_out = 1'b0,
    i_imm   = 1'b1
  } cmpmux_sel_t;

  // Bit positions inside the packed stage payload {redirect_pc, illegal, mispredict, taken}.
  localparam int unsigned TakenBit = 0;
  localparam int unsigned MispBit  = 1;
  localparam int unsigned IllBit   = 2;
  localparam int unsigned PcLsb    = 3;

endpackage

// File: rtl/br_resolve_if.sv
// Request/result handshake bundle between the EX operand mux, br_resolve and fetch redirect.
interface br_resolve_if #(
  parameter int unsigned WIDTH = 32
);
  import br_resolve_pkg::*;

  logic             in_valid;
  logic             in_ready;
  branch_funct3_t   in_op;
  cmpmux_sel_t      in_sel;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_imm;
  logic             in_pred_taken;
  logic [WIDTH-1:0] in_target;
  logic [WIDTH-1:0] in_fallthru;

  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic             out_mispredict;
  logic             out_illegal;
  logic [WIDTH-1:0] out_redirect_pc;

  modport master (
    output in_valid, in_op, in_sel, in_a, in_b, in_imm, in_pred_taken, in_target, in_fallthru,
    input  in_ready,
    input  out_valid, out_taken, out_mispredict, out_illegal, out_redirect_pc,
    output out_ready
  );

  modport slave (
    input  in_valid, in_op, in_sel, in_a, in_b, in_imm, in_pred_taken, in_target, in_fallthru,
    output in_ready,
    output out_valid, out_taken, out_mispredict, out_illegal, out_redirect_pc,
    input  out_ready
  );

endinterface

// File: rtl/br_pipe_slice.sv
// One valid/ready register slice with flush; ready passes through combinationally.
module br_pipe_slice #(
  parameter int unsigned WIDTH = 35
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
      end
    end
    if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/br_resolve.sv
// Pipelined branch resolution: compare, predict-check, redirect, plus saturating retire counters.
module br_resolve
  import br_resolve_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             cnt_clear_i,
  br_resolve_if.slave      br_io,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispred_count_o
);

  localparam int unsigned PayloadW = 3 + WIDTH;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [WIDTH-1:0]    arg2;
  logic                taken, illegal, mispredict;
  logic [WIDTH-1:0]    redirect_pc;
  logic [PayloadW-1:0] payload_in;

  always_comb begin
    arg2    = (br_io.in_sel == rs2_out) ? br_io.in_b : br_io.in_imm;
    taken   = 1'b0;
    illegal = 1'b0;
    case (br_io.in_op)
      beq:     taken = (br_io.in_a == arg2);
      bne:     taken = (br_io.in_a != arg2);
      blt:     taken = ($signed(br_io.in_a) <  $signed(arg2));
      bge:     taken = ($signed(br_io.in_a) >= $signed(arg2));
      bltu:    taken = (br_io.in_a <  arg2);
      bgeu:    taken = (br_io.in_a >= arg2);
      default: illegal = 1'b1;
    endcase
    mispredict  = !illegal && (taken != br_io.in_pred_taken);
    redirect_pc = taken ? br_io.in_target : br_io.in_fallthru;
  end

  assign payload_in = {redirect_pc, illegal, mispredict, taken};

  logic                valid_s [STAGES+1];
  logic                ready_s [STAGES+1];
  logic [PayloadW-1:0] data_s  [STAGES+1];

  assign valid_s[0]      = br_io.in_valid && !flush_i;
  assign data_s[0]       = payload_in;
  assign br_io.in_ready  = !flush_i && ready_s[0];
  assign ready_s[STAGES] = br_io.out_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    br_pipe_slice #(
      .WIDTH (PayloadW)
    ) u_slice (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .valid_i (valid_s[g]),
      .ready_o (ready_s[g]),
      .data_i  (data_s[g]),
      .valid_o (valid_s[g+1]),
      .ready_i (ready_s[g+1]),
      .data_o  (data_s[g+1])
    );
  end

  assign br_io.out_valid       = valid_s[STAGES];
  assign br_io.out_taken       = data_s[STAGES][TakenBit];
  assign br_io.out_mispredict  = data_s[STAGES][MispBit];
  assign br_io.out_illegal     = data_s[STAGES][IllBit];
  assign br_io.out_redirect_pc = data_s[STAGES][PayloadW-1:PcLsb];

  logic             out_hs;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mp_cnt_q, mp_cnt_d;

  assign out_hs = br_io.out_valid && br_io.out_ready;

  // Clear wins over a same-cycle retire; increments stop at all-ones.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (cnt_clear_i) begin
      br_cnt_d = '0;
      mp_cnt_d = '0;
    end else if (out_hs) begin
      if (!br_io.out_illegal && (br_cnt_q != '1)) begin
        br_cnt_d = br_cnt_q + CntOne;
      end
      if (br_io.out_mispredict && (mp_cnt_q != '1)) begin
        mp_cnt_d = mp_cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign br_count_o      = br_cnt_q;
  assign mispred_count_o = mp_cnt_q;

endmodule

// File: tb/tb_br_resolve.sv
// Randomized scoreboard bench for br_resolve with a spec-level reference model.
module tb_br_resolve;
  import br_resolve_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 3;
  localparam int unsigned CW = 4;
  localparam int CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] br_count, mispred_count;

  br_resolve_if #(.WIDTH(W)) bus ();

  br_resolve #(
    .WIDTH  (W),
    .STAGES (S),
    .CNT_W  (CW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .cnt_clear_i     (cnt_clear),
    .br_io           (bus),
    .br_count_o      (br_count),
    .mispred_count_o (mispred_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]   op;
    logic         sel;
    logic [W-1:0] a, b, imm, tgt, ft;
    logic         pred;
  } req_t;

  typedef struct {
    logic         taken, misp, ill;
    logic [W-1:0] pc;
    int           cyc;
    bit           lat_chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   br_m = 0;
  int   mp_m = 0;

  bit   rdy_rand = 0, flush_rand = 0, lat_mode = 0;
  logic rdy_val = 1'b1, flush_v = 1'b0, clr_v = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: branch rules straight from the ISA definition.
  function automatic exp_t model(input req_t r);
    exp_t         e;
    logic [W-1:0] arg2;
    arg2 = r.sel ? r.imm : r.b;
    e.taken = 1'b0;
    e.ill = 1'b0;
    case (r.op)
      3'd0: e.taken = (r.a == arg2);
      3'd1: e.taken = (r.a != arg2);
      3'd4: e.taken = ($signed(r.a) < $signed(arg2));
      3'd5: e.taken = !($signed(r.a) < $signed(arg2));
      3'd6: e.taken = (r.a < arg2);
      3'd7: e.taken = !(r.a < arg2);
      default: e.ill = 1'b1;
    endcase
    e.misp = !e.ill && (e.taken != r.pred);
    e.pc = e.taken ? r.tgt : r.ft;
    e.cyc = 0;
    e.lat_chk = 0;
    return e;
  endfunction

  function automatic req_t mk(input logic [2:0] op, input logic sel, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] imm, input logic pred);
    req_t r;
    r.op = op; r.sel = sel; r.a = a; r.b = b; r.imm = imm; r.pred = pred;
    r.tgt = $urandom;
    r.ft = $urandom;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r = mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)));
    if ($urandom_range(0, 2) == 0) r.b = r.a;
    if ($urandom_range(0, 2) == 0) r.imm = r.a;
    if ($urandom_range(0, 3) == 0) r.a = r.a ^ 32'h8000_0000;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    flush = flush_rand ? ($urandom_range(0, 24) == 0) : flush_v;
    cnt_clear = flush_rand ? ($urandom_range(0, 49) == 0) : clr_v;
  endtask

  task automatic offer(input req_t r, output logic acc);
    exp_t e;
    tick();
    bus.in_valid = 1'b1;
    bus.in_op = branch_funct3_t'(r.op);
    bus.in_sel = cmpmux_sel_t'(r.sel);
    bus.in_a = r.a;
    bus.in_b = r.b;
    bus.in_imm = r.imm;
    bus.in_pred_taken = r.pred;
    bus.in_target = r.tgt;
    bus.in_fallthru = r.ft;
    #1;
    acc = bus.in_ready;
    if (acc) begin
      e = model(r);
      e.cyc = cyc + 1;
      e.lat_chk = lat_mode;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input req_t r, output int tries);
    logic acc;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      offer(r, acc);
      tries++;
    end
    check("send_accepted", acc, 1);
  endtask

  task automatic send1(input req_t r);
    int t;
    send(r, t);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      idle(1);
      #1;
      k++;
    end
    idle(1);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_out_valid();
    int k;
    k = 0;
    idle(1);
    #1;
    while (!bus.out_valid && k < 10) begin
      idle(1);
      #1;
      k++;
    end
    check("wait_out_valid", bus.out_valid, 1);
  endtask

  // Monitor: compares the presented result with the scoreboard head and tracks counters.
  exp_t me;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
      br_m = 0;
      mp_m = 0;
    end else begin
      check("br_count", br_count, br_m);
      check("mispred_count", mispred_count, mp_m);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", bus.out_valid, 0);
        end else begin
          me = exp_q[0];
          check("out_taken", bus.out_taken, me.taken);
          check("out_mispredict", bus.out_mispredict, me.misp);
          check("out_illegal", bus.out_illegal, me.ill);
          check("out_redirect_pc", bus.out_redirect_pc, me.pc);
          if (bus.out_ready) begin
            if (me.lat_chk) check("latency", cyc - me.cyc, S - 1);
            void'(exp_q.pop_front());
            if (!me.ill && br_m < CntMax) br_m++;
            if (me.misp && mp_m < CntMax) mp_m++;
          end
        end
      end
      if (cnt_clear) begin
        br_m = 0;
        mp_m = 0;
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    logic acc;
    int   tries, na;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_op = beq;
    bus.in_sel = rs2_out;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_imm = '0;
    bus.in_pred_taken = 1'b0;
    bus.in_target = '0;
    bus.in_fallthru = '0;

    repeat (3) tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_taken", bus.out_taken, 0);
    check("rst_out_mispredict", bus.out_mispredict, 0);
    check("rst_out_illegal", bus.out_illegal, 0);
    check("rst_out_pc", bus.out_redirect_pc, 0);
    check("rst_br_count", br_count, 0);
    check("rst_mispred_count", mispred_count, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Directed corner cases, latency checked on every result.
    lat_mode = 1;
    send1(mk(3'd4, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0));
    send1(mk(3'd6, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0));
    send1(mk(3'd5, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h5, 1'b0));
    send1(mk(3'd7, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h5, 1'b1));
    send1(mk(3'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h5, 1'b0));
    send1(mk(3'd1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h5, 1'b1));
    send1(mk(3'd2, 1'b0, 32'h1, 32'h1, 32'h1, 1'b1));
    send1(mk(3'd3, 1'b1, 32'h1, 32'h2, 32'h1, 1'b0));
    wait_drain("drain_directed");

    // Back-to-back: no stalls, fixed latency.
    for (int i = 0; i < 10; i++) begin
      send(rand_req(), tries);
      check("b2b_first_try", tries, 1);
    end
    wait_drain("drain_b2b");
    lat_mode = 0;

    // Backpressure: exactly S absorbed, ready follows out_ready combinationally.
    rdy_val = 1'b0;
    r = rand_req();
    na = 0;
    for (int i = 0; i < 6; i++) begin
      offer(r, acc);
      if (acc) begin
        na++;
        r = rand_req();
      end
    end
    check("bp_absorb_count", na, S);
    check("bp_in_ready_low", bus.in_ready, 0);
    rdy_val = 1'b1;
    offer(r, acc);
    check("bp_ready_rise", acc, 1);
    wait_drain("drain_bp");

    // Flush with two in flight and a request offered.
    rdy_val = 1'b0;
    send1(rand_req());
    send1(rand_req());
    flush_v = 1'b1;
    rdy_val = 1'b1;
    offer(rand_req(), acc);
    check("flush_blocks_input", acc, 0);
    flush_v = 1'b0;
    idle(1);
    #1;
    check("flush_clears_valid", bus.out_valid, 0);

    // Flush while the output handshakes: that one still retires.
    rdy_val = 1'b0;
    for (int i = 0; i < 3; i++) send1(rand_req());
    wait_out_valid();
    flush_v = 1'b1;
    rdy_val = 1'b1;
    idle(1);
    flush_v = 1'b0;
    idle(1);
    #1;
    check("flush_hs_valid", bus.out_valid, 0);
    wait_drain("drain_flush");

    // Saturation of both counters.
    clr_v = 1'b1;
    idle(1);
    clr_v = 1'b0;
    for (int i = 0; i < 16; i++) send1(mk(3'd0, 1'b0, 32'h0, 32'h0, 32'h7, 1'b0));
    wait_drain("drain_sat");
    check("sat_br_count", br_count, 4'hF);
    check("sat_mispred_count", mispred_count, 4'hF);

    // Clear beats a same-cycle retire.
    rdy_val = 1'b0;
    send1(mk(3'd1, 1'b0, 32'h1, 32'h2, 32'h0, 1'b0));
    wait_out_valid();
    clr_v = 1'b1;
    rdy_val = 1'b1;
    idle(1);
    clr_v = 1'b0;
    idle(1);
    #1;
    check("clr_br_count", br_count, 0);
    check("clr_mispred_count", mispred_count, 0);

    // Random traffic with random backpressure, flush and clear.
    rdy_rand = 1;
    flush_rand = 1;
    for (int i = 0; i < 400; i++) send1(rand_req());
    rdy_rand = 0;
    flush_rand = 0;
    rdy_val = 1'b1;
    wait_drain("drain_random");

    // Reset mid-operation.
    send1(rand_req());
    send1(rand_req());
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_br_count", br_count, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 5; i++) send1(rand_req());
    wait_drain("drain_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/br_resolve.md
# br_resolve

Parametrised, pipelined branch-resolution unit for the mp3 core. It accepts one branch per cycle over a valid/ready handshake and evaluates all six RV32I branch conditions against a selected second operand. It compares the outcome with the fetch-stage prediction and returns taken, mispredict and redirect PC after a fixed, parameter-set latency. It supports pipeline flush and keeps saturating branch/mispredict performance counters; it sits between the EX-stage operand mux and the fetch redirect logic.

## Interface
- WIDTH, 32, operand and PC width in bits (≥ 8)
- STAGES, 1, register slices between input and output (1..3)
- CNT_W, 32, width of each performance counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all in-flight entries; block input this cycle
- in_valid  in  1  request present
- in_ready  out  1  unit can accept request this cycle
- in_op  in  branch_funct3_t  comparison select
- in_sel  in  cmpmux::cmpmux_sel_t  second operand: rs2_out → in_b, otherwise in_imm
- in_a, in_b, in_imm  in  WIDTH  rs1, rs2, sign-extended immediate
- in_pred_taken  in  1  fetch-stage prediction
- in_target, in_fallthru  in  WIDTH  taken PC, PC+4
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_taken, out_mispredict, out_illegal  out  1  resolved outcome flags
- out_redirect_pc  out  WIDTH  correct next PC
- cnt_clear  in  1  zero both counters
- br_count, mispred_count  out  CNT_W  retired branches / retired mispredicts

## Operation
- arg2 = (in_sel == rs2_out) ? in_b : in_imm. All six ops use arg2, including signed and unsigned ones.
- beq: a==arg2; bne: a!=arg2; blt/bge: signed </>=; bltu/bgeu: unsigned </>=.
- funct3 010/011: taken=0, illegal=1, mispredict=0.
- Comparison is combinational on the input side. Its result plus the payload (taken, mispredict, illegal, redirect PC) is captured into stage 1.
- mispredict = !illegal && (taken != pred_taken). redirect_pc = taken ? target : fallthru.
- Each stage is a valid/ready slice. A stage loads when it is empty or its downstream consumer accepts this cycle. in_ready = !flush && (stage 1 empty || stage 1 advancing).
- out_* come from the last stage's registers. The payload stays stable while out_valid && !out_ready.
- flush: at the next edge every stage's valid bit is cleared. A request offered in the flush cycle is not accepted. An output handshake in the flush cycle still completes and still counts.
- Counters advance on an output handshake (out_valid && out_ready):
  - br_count +1 if !illegal.
  - mispred_count +1 if mispredict.
  - Both saturate at all-ones.
  - cnt_clear zeroes both, taking priority over an increment in the same cycle.

## Timing
- Reset: all valid bits 0, out_valid=0, all out_* payload 0, counters 0. in_ready = 1 in the first cycle after reset if flush=0.
- rst mid-operation discards all in-flight entries with no handshake, and has priority over flush and cnt_clear.
- Latency: a request accepted at edge N gives out_valid=1 after edge N+STAGES-1 (visible the cycle after N+STAGES-1) when out_ready is held high.
- Throughput: 1 request/cycle with out_ready=1. No bubbles are inserted at any STAGES value.
- Backpressure: with out_ready=0, the unit absorbs exactly STAGES requests, then in_ready=0. in_ready rises in the same cycle out_ready rises (combinational ready chain).
- in_valid without in_ready: the request is not taken. The producer holds it.

## Structure
- Existing rv32i_types: branch_funct3_t and cmpmux_sel_t; add no new enums.
- Stage payload is a packed vector of width 3+WIDTH, built by localparam; no struct (WIDTH is parametric).
- One sub-module, br_pipe_slice (WIDTH-parametrised valid/ready register with flush), instantiated STAGES times in a generate loop.
- Counter logic stays in br_resolve.

## Test plan
- WIDTH=32, STAGES=1: blt a=0xFFFFFFFF, in_sel=imm, imm=1, pred=0 → taken=1, mispredict=1, redirect=target. Same with bltu → taken=0, mispredict=0.
- bge/bgeu/beq/bne sweep, in_sel=rs2_out, a=b=0x80000000 → taken 1/1/1/0. Op 010 → illegal=1, br_count unchanged.
- STAGES=3, 10 back-to-back requests, out_ready=1 → first out_valid 3 cycles after first accept, then 10 consecutive results in order.
- STAGES=2, out_ready=0 → in_ready falls after 2 accepts. Payload held stable; release gives order preserved, no loss or duplication.
- Flush with 2 entries in flight and in_valid=1 → out_valid=0 next cycle, request not accepted, counters reflect only pre-flush handshakes.
- CNT_W=4: 16 mispredicting branches → both counters saturate at 0xF. cnt_clear plus handshake in the same cycle → 0.
